// File: rtl/smg_page_sched.sv
// rtl/smg_page_sched.sv - seven-segment page rotation scheduler with alert pre-emption
// Rotates the display through enabled 16-bit sources; a rising alert request overrides it for a fixed hold.
module smg_page_sched #(
  parameter int unsigned DWELL_CYCLES = 100_000_000,
  parameter int unsigned ALERT_HOLD   = 200_000_000
) (
  input  logic        clk_100MHz,
  input  logic        rst,
  input  logic [15:0] motor_data,
  input  logic [15:0] sensor_data,
  input  logic [15:0] path_data,
  input  logic [15:0] status_data,
  input  logic [3:0]  page_en,
  input  logic        freeze,
  input  logic        alert_req,
  input  logic [15:0] alert_data,
  output logic        alert_ack,
  output logic        alert_active,
  output logic [15:0] data,
  output logic [1:0]  page,
  output logic        page_tick
);

  localparam logic ST_ROTATE = 1'b0;
  localparam logic ST_ALERT  = 1'b1;

  localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST  = 32'(ALERT_HOLD - 1);

  logic        state_q, state_d;
  logic [31:0] dwell_q, dwell_d;
  logic [31:0] hold_q, hold_d;
  logic [15:0] data_q, data_d;
  logic [1:0]  page_q, page_d;
  logic        ack_q, ack_d;
  logic        active_q, active_d;
  logic        tick_q, tick_d;
  logic        req_prev_q, req_prev_d;

  logic [15:0] srcs [4];
  logic [1:0]  next_pg;
  logic        found;
  logic [1:0]  cand;
  logic        rise;

  assign srcs[0] = motor_data;
  assign srcs[1] = sensor_data;
  assign srcs[2] = path_data;
  assign srcs[3] = status_data;

  assign rise = alert_req & ~req_prev_q;

  // Round-robin search from page+1; the fourth candidate wraps back to the current page.
  always_comb begin
    next_pg = page_q;
    found   = 1'b0;
    cand    = page_q;
    for (int i = 1; i <= 4; i++) begin
      cand = page_q + 2'(i);
      if (!found && page_en[cand]) begin
        next_pg = cand;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    dwell_d    = dwell_q;
    hold_d     = hold_q;
    data_d     = data_q;
    page_d     = page_q;
    ack_d      = 1'b0;
    active_d   = active_q;
    tick_d     = 1'b0;
    req_prev_d = alert_req;

    if (state_q == ST_ROTATE) begin
      if (rise) begin
        state_d  = ST_ALERT;
        data_d   = alert_data;
        ack_d    = 1'b1;
        active_d = 1'b1;
        hold_d   = 32'd0;
        dwell_d  = 32'd0;
      end else if (page_en == 4'b0000) begin
        data_d  = 16'h0000;
        dwell_d = 32'd0;
      end else if (!page_en[page_q] || (!freeze && dwell_q == DWELL_LAST)) begin
        page_d  = next_pg;
        dwell_d = 32'd0;
        tick_d  = 1'b1;
        data_d  = srcs[next_pg];
      end else begin
        dwell_d = freeze ? dwell_q : dwell_q + 32'd1;
        data_d  = srcs[page_q];
      end
    end else begin
      if (rise) begin
        data_d = alert_data;
        ack_d  = 1'b1;
        hold_d = 32'd0;
      end else if (hold_q == HOLD_LAST) begin
        // Return on the same page; a page disabled meanwhile is skipped on the following edge.
        state_d  = ST_ROTATE;
        active_d = 1'b0;
        dwell_d  = 32'd0;
        hold_d   = 32'd0;
        tick_d   = (page_en != 4'b0000);
        data_d   = (page_en == 4'b0000) ? 16'h0000 : srcs[page_q];
      end else begin
        hold_d = hold_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state_q    <= ST_ROTATE;
      dwell_q    <= 32'd0;
      hold_q     <= 32'd0;
      data_q     <= 16'h0000;
      page_q     <= 2'd0;
      ack_q      <= 1'b0;
      active_q   <= 1'b0;
      tick_q     <= 1'b0;
      req_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      hold_q     <= hold_d;
      data_q     <= data_d;
      page_q     <= page_d;
      ack_q      <= ack_d;
      active_q   <= active_d;
      tick_q     <= tick_d;
      req_prev_q <= req_prev_d;
    end
  end

  assign alert_ack    = ack_q;
  assign alert_active = active_q;
  assign data         = data_q;
  assign page         = page_q;
  assign page_tick    = tick_q;

endmodule

// File: tb/tb_smg_page_sched.sv
// tb/tb_smg_page_sched.sv - directed and random checks of smg_page_sched against a cycle model
`timescale 1ns/1ps
module tb_smg_page_sched;

  localparam int DW = 4;
  localparam int AH = 6;

  logic        clk_100MHz = 1'b0;
  logic        rst;
  logic [15:0] motor_data, sensor_data, path_data, status_data, alert_data;
  logic [3:0]  page_en;
  logic        freeze, alert_req;
  logic        alert_ack, alert_active, page_tick;
  logic [15:0] data;
  logic [1:0]  page;

  smg_page_sched #(.DWELL_CYCLES(DW), .ALERT_HOLD(AH)) dut (
    .clk_100MHz  (clk_100MHz),
    .rst         (rst),
    .motor_data  (motor_data),
    .sensor_data (sensor_data),
    .path_data   (path_data),
    .status_data (status_data),
    .page_en     (page_en),
    .freeze      (freeze),
    .alert_req   (alert_req),
    .alert_data  (alert_data),
    .alert_ack   (alert_ack),
    .alert_active(alert_active),
    .data        (data),
    .page        (page),
    .page_tick   (page_tick)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int total = 0;
  int bad   = 0;

  // Model: elapsed cycles on the current page, alert cycles still to show.
  bit          m_alert;
  int          m_page, m_elapsed, m_left;
  bit          m_prev;
  logic [15:0] e_data;
  bit          e_ack, e_tick;

  function automatic logic [15:0] src_of(int p);
    case (p)
      0: return motor_data;
      1: return sensor_data;
      2: return path_data;
      default: return status_data;
    endcase
  endfunction

  function automatic int next_en(int p);
    for (int k = 1; k <= 4; k++)
      if (page_en[(p + k) % 4]) return (p + k) % 4;
    return p;
  endfunction

  task automatic model_edge();
    bit rise, go;
    if (rst) begin
      m_alert = 0; m_page = 0; m_elapsed = 0; m_left = 0; m_prev = 1;
      e_data = 16'h0; e_ack = 0; e_tick = 0;
      return;
    end
    rise   = alert_req && !m_prev;
    m_prev = alert_req;
    e_ack  = 0;
    e_tick = 0;
    if (rise) begin
      m_alert = 1; m_left = AH; e_data = alert_data; e_ack = 1;
    end else if (m_alert) begin
      m_left--;
      if (m_left == 0) begin
        m_alert = 0; m_elapsed = 0;
        e_tick = (page_en != 0);
        e_data = (page_en == 0) ? 16'h0 : src_of(m_page);
      end
    end else if (page_en == 0) begin
      e_data = 16'h0; m_elapsed = 0;
    end else begin
      go = !page_en[m_page];
      if (!go && !freeze) begin
        m_elapsed++;
        go = (m_elapsed == DW);
      end
      if (go) begin
        m_page = next_en(m_page); m_elapsed = 0; e_tick = 1;
      end
      e_data = src_of(m_page);
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_100MHz);
    model_edge();
    #1;
    chk("data", 32'(data), 32'(e_data));
    chk("page", 32'(page), m_page);
    chk("ack", 32'(alert_ack), 32'(e_ack));
    chk("active", 32'(alert_active), 32'(m_alert));
    chk("tick", 32'(page_tick), 32'(e_tick));
  endtask

  task automatic wait_page(int p);
    for (int n = 0; n < 40; n++) begin
      if (m_page == p && !m_alert) return;
      step();
    end
    total++; bad++;
    $error("FAIL wait_page observed=%0d expected=%0d", m_page, p);
  endtask

  initial begin
    int acks, act, n, p;
    rst = 1; alert_req = 1; freeze = 0; page_en = 4'b1111;
    motor_data = 16'h1111; sensor_data = 16'h2222; path_data = 16'h3333; status_data = 16'h4444;
    alert_data = 16'h0;
    step(); step();
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_page", 32'(page), 32'h0);

    // Request held high across reset release must not be accepted; rotation from page 0.
    rst = 0;
    for (int i = 0; i < 4; i++) step();
    chk("rot_page1", 32'(page), 32'd1);
    chk("rot_data1", 32'(data), 32'h2222);
    chk("rot_tick1", 32'(page_tick), 32'd1);
    chk("held_no_ack", 32'(alert_ack), 32'd0);
    alert_req = 0;
    for (int i = 0; i < 14; i++) step();

    // Sparse mask, then disable the current page, then disable all.
    page_en = 4'b0101;
    for (int i = 0; i < 12; i++) step();
    wait_page(2);
    page_en = 4'b0001;
    step();
    chk("dis_page", 32'(page), 32'd0);
    chk("dis_tick", 32'(page_tick), 32'd1);
    page_en = 4'b0000;
    step();
    chk("none_data", 32'(data), 32'h0);
    for (int i = 0; i < 5; i++) step();

    // Alert on page 1.
    page_en = 4'b1111;
    wait_page(1);
    alert_data = 16'hBEEF; alert_req = 1;
    step();
    chk("al_ack", 32'(alert_ack), 32'd1);
    chk("al_data", 32'(data), 32'hBEEF);
    alert_req = 0;
    for (int i = 0; i < AH - 1; i++) step();
    chk("al_still", 32'(alert_active), 32'd1);
    step();
    chk("al_ret_page", 32'(page), 32'd1);
    chk("al_ret_data", 32'(data), 32'h2222);
    chk("al_ret_tick", 32'(page_tick), 32'd1);

    // Level request: one ack, six alert cycles.
    step();
    alert_req = 1; acks = 0; act = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      acks += int'(alert_ack);
      act  += int'(alert_active);
    end
    chk("lvl_acks", acks, 1);
    chk("lvl_len", act, AH);

    // Retrigger at hold count 3.
    alert_req = 0; step();
    alert_req = 1; alert_data = 16'h1234; step();
    alert_req = 0; step(); step(); step();
    alert_req = 1; alert_data = 16'hCAFE; step();
    chk("rt_ack", 32'(alert_ack), 32'd1);
    chk("rt_data", 32'(data), 32'hCAFE);
    alert_req = 0; n = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!alert_active) break;
      n++;
    end
    chk("rt_len", n, AH);

    // Freeze holds the page.
    freeze = 1; p = m_page;
    for (int i = 0; i < 10; i++) step();
    chk("frz_page", 32'(page), p);
    freeze = 0;

    // Alert edge on the dwell terminal cycle.
    for (int i = 0; i < 10 && m_elapsed != DW - 1; i++) step();
    p = m_page; alert_req = 1;
    step();
    chk("co_page", 32'(page), p);
    chk("co_active", 32'(alert_active), 32'd1);
    alert_req = 0; step();

    // Reset mid-alert with a coincident request edge.
    rst = 1; alert_req = 1;
    step();
    chk("mr_ack", 32'(alert_ack), 32'd0);
    chk("mr_active", 32'(alert_active), 32'd0);
    chk("mr_data", 32'(data), 32'h0);
    step();
    rst = 0;
    for (int i = 0; i < 3; i++) step();
    chk("mr_held", 32'(alert_ack), 32'd0);
    alert_req = 0; step();
    alert_req = 1; step();
    chk("mr_reack", 32'(alert_ack), 32'd1);
    alert_req = 0;

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0) page_en = 4'($urandom);
      freeze = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) alert_req = ~alert_req;
      alert_data = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        motor_data = 16'($urandom); sensor_data = 16'($urandom);
        path_data  = 16'($urandom); status_data = 16'($urandom);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
